// File: rtl/mem_arbiter.sv
// Two-master arbiter (CPU and program loader) in front of a single-port synchronous RAM.
// Each access takes an address cycle and a data cycle; done/rdata are registered on exit.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCAddr = 3'd1,
    StCData = 3'd2,
    StLAddr = 3'd3,
    StLData = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                last_ldr_q, last_ldr_d;
  logic                cpu_done_q, ldr_done_q;
  logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;

  always_comb begin
    state_d    = state_q;
    last_ldr_d = last_ldr_q;
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Lock locks the CPU out entirely; otherwise round-robin on a tie.
        if (ldr_lock) begin
          if (ldr_req) state_d = StLAddr;
        end else if (cpu_req && ldr_req) begin
          state_d = last_ldr_q ? StCAddr : StLAddr;
        end else if (cpu_req) begin
          state_d = StCAddr;
        end else if (ldr_req) begin
          state_d = StLAddr;
        end
        if (state_d == StCAddr) last_ldr_d = 1'b0;
        if (state_d == StLAddr) last_ldr_d = 1'b1;
      end
      StCAddr: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        state_d   = StCData;
      end
      StCData: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        state_d   = StIdle;
      end
      StLAddr: begin
        ldr_gnt   = 1'b1;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_we    = ldr_we;
        state_d   = StLData;
      end
      StLData: begin
        ldr_gnt   = 1'b1;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      last_ldr_q  <= 1'b1;
      cpu_done_q  <= 1'b0;
      ldr_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ldr_q <= last_ldr_d;
      cpu_done_q <= (state_q == StCData);
      ldr_done_q <= (state_q == StLData);
      // RAM data for the address cycle is valid during the data cycle.
      if (state_q == StCData && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (state_q == StLData && !ldr_we) ldr_rdata_q <= mem_rdata;
    end
  end

  assign cpu_done  = cpu_done_q;
  assign ldr_done  = ldr_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16x8 synchronous RAM model.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [3:0] cpu_addr, ldr_addr;
  logic [7:0] cpu_wdata, ldr_wdata;
  logic       cpu_gnt, cpu_done, ldr_gnt, ldr_done;
  logic [7:0] cpu_rdata, ldr_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = '0;

  logic [7:0] ram [16] = '{8'h00, 8'h01, 8'h02, 8'h5A, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

  int n_tests;
  int n_fail;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_lock  (ldr_lock),
    .ldr_gnt   (ldr_gnt),
    .ldr_done  (ldr_done),
    .ldr_rdata (ldr_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    cpu_req  = 1'b0;
    ldr_req  = 1'b0;
    ldr_lock = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cpu_we    = 1'b0;
    ldr_we    = 1'b0;
    cpu_addr  = '0;
    ldr_addr  = '0;
    cpu_wdata = '0;
    ldr_wdata = '0;
    do_reset();
    step();

    // Reset state
    check_eq("rst_cpu_gnt", cpu_gnt, 0);
    check_eq("rst_ldr_gnt", ldr_gnt, 0);
    check_eq("rst_cpu_done", cpu_done, 0);
    check_eq("rst_ldr_done", ldr_done, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_ldr_rdata", ldr_rdata, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);

    // CPU read of RAM[3]
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    check_eq("rd_c0_gnt", cpu_gnt, 0);
    step();
    check_eq("rd_c1_gnt", cpu_gnt, 1);
    check_eq("rd_c1_addr", mem_addr, 4'h3);
    check_eq("rd_c1_we", mem_we, 0);
    check_eq("rd_c1_done", cpu_done, 0);
    cpu_req = 1'b0;
    step();
    check_eq("rd_c2_gnt", cpu_gnt, 1);
    check_eq("rd_c2_done", cpu_done, 0);
    step();
    check_eq("rd_c3_gnt", cpu_gnt, 0);
    check_eq("rd_c3_done", cpu_done, 1);
    check_eq("rd_c3_rdata", cpu_rdata, 8'h5A);
    step();
    check_eq("rd_c4_done", cpu_done, 0);

    // Loader write 0xA5 to 0xF
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hF; ldr_wdata = 8'hA5;
    check_eq("wr_c0_we", mem_we, 0);
    step();
    check_eq("wr_c1_gnt", ldr_gnt, 1);
    check_eq("wr_c1_cpu_gnt", cpu_gnt, 0);
    check_eq("wr_c1_we", mem_we, 1);
    check_eq("wr_c1_addr", mem_addr, 4'hF);
    check_eq("wr_c1_wdata", mem_wdata, 8'hA5);
    ldr_req = 1'b0;
    step();
    check_eq("wr_c2_we", mem_we, 0);
    check_eq("wr_c2_gnt", ldr_gnt, 1);
    check_eq("wr_c2_done", ldr_done, 0);
    step();
    check_eq("wr_c3_done", ldr_done, 1);
    check_eq("wr_c3_rdata_held", ldr_rdata, 0);
    check_eq("wr_c3_ram", ram[15], 8'hA5);
    check_eq("wr_c3_cpu_rdata", cpu_rdata, 8'h5A);
    check_eq("wr_c3_cpu_done", cpu_done, 0);

    // Round-robin with both requesting from reset: CPU, LDR, CPU, LDR
    do_reset();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      step();
      begin
        logic exp_cg, exp_lg, exp_cd, exp_ld;
        exp_cg = ((c - 1) % 3 != 2) && (((c - 1) / 3) % 2 == 0);
        exp_lg = ((c - 1) % 3 != 2) && (((c - 1) / 3) % 2 == 1);
        exp_cd = (c % 3 == 0) && (((c / 3) - 1) % 2 == 0);
        exp_ld = (c % 3 == 0) && (((c / 3) - 1) % 2 == 1);
        check_eq($sformatf("rr_c%0d_cpu_gnt", c), cpu_gnt, exp_cg);
        check_eq($sformatf("rr_c%0d_ldr_gnt", c), ldr_gnt, exp_lg);
        check_eq($sformatf("rr_c%0d_cpu_done", c), cpu_done, exp_cd);
        check_eq($sformatf("rr_c%0d_ldr_done", c), ldr_done, exp_ld);
      end
    end
    check_eq("rr_cpu_rdata", cpu_rdata, 8'h5A);
    check_eq("rr_ldr_rdata", ldr_rdata, 8'hA5);

    // Lock: loader back-to-back, CPU starved
    ldr_lock = 1'b1;
    for (int c = 13; c <= 18; c++) begin
      step();
      check_eq($sformatf("lk_c%0d_cpu_gnt", c), cpu_gnt, 0);
      check_eq($sformatf("lk_c%0d_ldr_gnt", c), ldr_gnt, ((c - 13) % 3 != 2));
      check_eq($sformatf("lk_c%0d_cpu_done", c), cpu_done, 0);
    end
    ldr_lock = 1'b0;
    step();
    check_eq("unlk_cpu_gnt", cpu_gnt, 1);
    check_eq("unlk_ldr_gnt", ldr_gnt, 0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    step();
    step();
    check_eq("unlk_cpu_done", cpu_done, 1);

    // Reset in L_ADDR of a write to 2
    do_reset();
    reset = 1'b0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h2; ldr_wdata = 8'h33;
    step();
    check_eq("ra_c1_ldr_gnt", ldr_gnt, 1);
    check_eq("ra_c1_we", mem_we, 1);
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    step();
    check_eq("ra_c2_we", mem_we, 0);
    check_eq("ra_c2_ldr_gnt", ldr_gnt, 0);
    check_eq("ra_c2_cpu_gnt", cpu_gnt, 0);
    check_eq("ra_c2_ldr_done", ldr_done, 0);
    check_eq("ra_c2_ram", ram[2], 8'h33);
    reset = 1'b0; ldr_we = 1'b0;
    step();
    check_eq("ra_c3_cpu_gnt", cpu_gnt, 1);
    check_eq("ra_c3_ldr_gnt", ldr_gnt, 0);
    check_eq("ra_c3_ldr_done", ldr_done, 0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    step();
    check_eq("ra_c4_ldr_done", ldr_done, 0);
    step();
    check_eq("ra_c5_cpu_done", cpu_done, 1);
    check_eq("ra_c5_cpu_rdata", cpu_rdata, 8'h5A);

    // CPU read with req dropped in C_ADDR, then CPU write keeps rdata
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hF;
    step();
    check_eq("ab_c1_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    step();
    step();
    check_eq("ab_c3_done", cpu_done, 1);
    check_eq("ab_c3_rdata", cpu_rdata, 8'hA5);
    step();
    check_eq("ab_c4_done", cpu_done, 0);
    check_eq("ab_c4_gnt", cpu_gnt, 0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h4; cpu_wdata = 8'h77;
    step();
    check_eq("cw_c1_gnt", cpu_gnt, 1);
    check_eq("cw_c1_we", mem_we, 1);
    cpu_req = 1'b0;
    step();
    step();
    check_eq("cw_c3_done", cpu_done, 1);
    check_eq("cw_c3_rdata_held", cpu_rdata, 8'hA5);
    check_eq("cw_c3_ram", ram[4], 8'h77);
    check_eq("cw_c3_ldr_done", ldr_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
